// File: rtl/xrisc_dbus_responder.sv
// xrisc_dbus_responder: data RAM, byte console (FIFO + 8N1 transmitter) and sticky result register on the core data bus
module xrisc_dbus_responder #(
    parameter int DMEM_WORDS   = 64,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Done,
    output logic        Pass,
    output logic        TxD,
    output logic        TxBusy
);
    localparam int AW = $clog2(DMEM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    logic [31:0]   mem [DMEM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [FW-1:0] wp, rp;
    logic [FW:0]   cnt;
    logic          ovf;
    state_t        state;
    logic [CW-1:0] ctr;
    logic [2:0]    idx;
    logic [7:0]    sh;
    logic          is_ram, is_con, is_sts, is_res, empty, full, push, pop, accept, last;
    always_comb begin
        is_ram   = DataAdr < 32'(4 * DMEM_WORDS);
        is_con   = DataAdr[31:2] == 30'h2000_0000;
        is_sts   = DataAdr[31:2] == 30'h2000_0001;
        is_res   = DataAdr[31:2] == 30'h2000_0002;
        empty    = cnt == '0;
        full     = cnt == (FW+1)'(FIFO_DEPTH);
        push     = MemWrite && is_con;
        pop      = state == IDLE && !empty;
        accept   = push && (!full || pop);
        last     = ctr == CW'(CLKS_PER_BIT - 1);
        TxBusy   = !empty || state != IDLE;
        ReadData = is_ram ? mem[DataAdr[AW+1:2]] :
                   is_sts ? {28'b0, ovf, TxBusy, full, empty} :
                   is_res ? {30'b0, Pass, Done} : 32'h0;
    end
    // storage arrays are intentionally left unreset
    always_ff @(posedge clk) begin
        if (MemWrite && is_ram) mem[DataAdr[AW+1:2]] <= WriteData;
        if (accept) fifo[wp] <= WriteData[7:0];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            if (accept) wp <= wp + FW'(1);
            if (pop) rp <= rp + FW'(1);
            if (push && !accept) ovf <= 1'b1;
            cnt <= cnt + (FW+1)'(accept) - (FW+1)'(pop);
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Done <= 1'b0;
            Pass <= 1'b0;
        end else if (MemWrite && is_res) begin
            Done <= 1'b1;
            Pass <= WriteData == 32'd1;
        end
    end
    // TxD is loaded with the level of the state being entered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ctr   <= '0;
            idx   <= '0;
            sh    <= '0;
            TxD   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    sh    <= fifo[rp];
                    state <= START;
                    ctr   <= '0;
                    TxD   <= 1'b0;
                end
                START: if (last) begin
                    state <= DATA;
                    ctr   <= '0;
                    idx   <= '0;
                    TxD   <= sh[0];
                end else ctr <= ctr + CW'(1);
                DATA: if (last) begin
                    ctr <= '0;
                    if (idx == 3'd7) begin
                        state <= STOP;
                        TxD   <= 1'b1;
                    end else begin
                        idx <= idx + 3'd1;
                        sh  <= sh >> 1;
                        TxD <= sh[1];
                    end
                end else ctr <= ctr + CW'(1);
                default: if (last) begin
                    state <= IDLE;
                    ctr   <= '0;
                end else ctr <= ctr + CW'(1);
            endcase
        end
    end
endmodule

// File: tb/tb_xrisc_dbus_responder.sv
// tb_xrisc_dbus_responder: directed checks of RAM, console framing, FIFO overflow, result register and reset
module tb_xrisc_dbus_responder;
    localparam int C = 4;
    localparam logic [31:0] CON = 32'h8000_0000, STS = 32'h8000_0004, RES = 32'h8000_0008;
    logic        clk = 1'b0, reset = 1'b0, MemWrite = 1'b0;
    logic [31:0] DataAdr = '0, WriteData = '0, ReadData;
    logic        Done, Pass, TxD, TxBusy;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    xrisc_dbus_responder #(.DMEM_WORDS(64), .FIFO_DEPTH(8), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
        .ReadData(ReadData), .Done(Done), .Pass(Pass), .TxD(TxD), .TxBusy(TxBusy)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic store(input logic [31:0] a, input logic [31:0] d);
        DataAdr = a;
        WriteData = d;
        MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask
    task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp);
        DataAdr = a;
        #1;
        chk(tag, ReadData, exp);
    endtask
    task automatic expect_frame(input logic [7:0] b, input int gap);
        logic e;
        repeat (gap) begin
            @(negedge clk);
            chk($sformatf("gap before %h", b), 32'(TxD), 32'd1);
        end
        for (int i = 0; i < 10 * C; i++) begin
            @(negedge clk);
            e = (i < C) ? 1'b0 : (i >= 9 * C) ? 1'b1 : b[i/C-1];
            chk($sformatf("frame %h bit %0d", b, i), 32'(TxD), 32'(e));
        end
    endtask
    task automatic quiet(input string tag);
        int lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (!TxD) lows++;
        end
        chk(tag, 32'(lows), 32'd0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("reset txd", 32'(TxD), 32'd1);
        chk("reset busy", 32'(TxBusy), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("reset done", 32'(Done), 32'd0);
        chk("reset pass", 32'(Pass), 32'd0);
        load("reset status", STS, 32'h1);
        load("console load", CON, 32'h0);
        @(negedge clk);
        store(32'h64, 32'h1234_5678);
        load("ram 0x64", 32'h64, 32'h1234_5678);
        load("ram 0x66", 32'h66, 32'h1234_5678);
        load("unmapped", 32'h9000_0000, 32'h0);
        load("past ram end", 32'h100, 32'h0);
        @(negedge clk);
        store(32'hFC, 32'hA5A5_0FF0);
        load("ram top word", 32'hFC, 32'hA5A5_0FF0);
        @(negedge clk);
        DataAdr = 32'h64;
        WriteData = 32'hCAFE_F00D;
        MemWrite = 1'b1;
        #1 chk("same-cycle store hidden", ReadData, 32'h1234_5678);
        @(negedge clk);
        MemWrite = 1'b0;
        #1 chk("store visible next cycle", ReadData, 32'hCAFE_F00D);
        @(negedge clk);
        store(CON, 32'h41);
        chk("busy after push", 32'(TxBusy), 32'd1);
        fork
            expect_frame(8'h41, 0);
            begin
                int n = 0;
                repeat (45) begin
                    if (TxBusy) n++;
                    @(negedge clk);
                end
                chk("busy clocks", 32'(n), 32'd41);
            end
        join
        chk("idle txd", 32'(TxD), 32'd1);
        chk("idle busy", 32'(TxBusy), 32'd0);
        fork
            begin
                DataAdr = CON;
                WriteData = 32'hA0;
                MemWrite = 1'b1;
                for (int i = 1; i < 10; i++) begin
                    @(negedge clk);
                    WriteData = 32'hA0 + 32'(i);
                end
                @(negedge clk);
                MemWrite = 1'b0;
                DataAdr = STS;
                #1 chk("overflow status", ReadData, 32'hE);
            end
            for (int i = 0; i < 9; i++) expect_frame(8'hA0 + 8'(i), 1);
        join
        quiet("no tenth frame");
        load("drained status", STS, 32'h9);
        @(negedge clk);
        store(RES, 32'd25);
        chk("done after 25", 32'(Done), 32'd1);
        chk("pass after 25", 32'(Pass), 32'd0);
        load("result after 25", RES, 32'h1);
        @(negedge clk);
        store(RES, 32'd1);
        load("result after 1", RES, 32'h3);
        @(negedge clk);
        DataAdr = CON;
        WriteData = 32'h00;
        MemWrite = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        MemWrite = 1'b0;
        repeat (4) @(negedge clk);
        chk("data bit low before reset", 32'(TxD), 32'd0);
        #2 reset = 1'b0;
        #1 chk("async reset txd", 32'(TxD), 32'd1);
        chk("async reset busy", 32'(TxBusy), 32'd0);
        chk("async reset done", 32'(Done), 32'd0);
        chk("async reset pass", 32'(Pass), 32'd0);
        load("async reset status", STS, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        quiet("no frame after reset");
        chk("busy after reset", 32'(TxBusy), 32'd0);
        fork
            begin
                DataAdr = CON;
                WriteData = 32'hC0;
                MemWrite = 1'b1;
                for (int i = 1; i < 9; i++) begin
                    @(negedge clk);
                    WriteData = 32'hC0 + 32'(i);
                end
                @(negedge clk);
                MemWrite = 1'b0;
                repeat (33) @(negedge clk);
                DataAdr = STS;
                #1 chk("full at idle", ReadData, 32'h6);
                DataAdr = CON;
                WriteData = 32'hC9;
                MemWrite = 1'b1;
                @(negedge clk);
                MemWrite = 1'b0;
                DataAdr = STS;
                #1 chk("push with pop while full", ReadData, 32'h6);
            end
            for (int i = 0; i < 10; i++) expect_frame(8'hC0 + 8'(i), 1);
        join
        repeat (2) @(negedge clk);
        load("final status", STS, 32'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xrisc_dbus_responder.md
# xrisc_dbus_responder

Data-bus responder for the single-cycle XRISC core: the slave end of the `MemWrite`/`DataAdr`/`WriteData` interface the core drives. It services core loads and stores with a word-addressed data RAM, a memory-mapped byte console (FIFO plus 8N1 serial transmitter), and a sticky test-result register. Benches and the FPGA top observe pass/fail on `Done`/`Pass` and console text on `TxD`.

## Interface
- `DMEM_WORDS`, 64: data RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 8: console FIFO depth in bytes; power of two, ≥2.
- `CLKS_PER_BIT`, 16: serial bit period in clocks; ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low: asserted at 0, released synchronously by the system.
- `MemWrite`  in  1  store strobe from the core, sampled every rising edge.
- `DataAdr`  in  32  byte address from the core; bits [1:0] ignored.
- `WriteData`  in  32  store data.
- `ReadData`  out  32  load data; combinational from `DataAdr`.
- `Done`  out  1  sticky; the core has written the result register.
- `Pass`  out  1  sticky; the result value was 1.
- `TxD`  out  1  serial console line; idle high.
- `TxBusy`  out  1  FIFO non-empty or transmitter not IDLE.

## Operation
- Address map, full 32-bit decode:
  - 0x0000_0000 to 4*DMEM_WORDS-1: RAM. Store writes the word at edge. Load reads combinationally; the same-cycle store is not visible. RAM contents are not reset.
  - 0x8000_0000 CONSOLE: store pushes `WriteData[7:0]`. Load returns 0.
  - 0x8000_0004 STATUS: load returns {28'b0, ovf, busy, full, empty}. Stores are ignored.
  - 0x8000_0008 RESULT: store sets `Done`=1 and `Pass`=(`WriteData`==32'd1). Later stores overwrite `Pass` and keep `Done`=1. Load returns {30'b0, Pass, Done}.
  - Any other address: stores are ignored; loads return 32'h0.
- FIFO: circular buffer with a count of 0..FIFO_DEPTH.
  - A push when full is dropped and sets sticky `ovf`, unless a pop occurs in the same cycle; in that case the push is accepted.
  - Simultaneous push and pop leaves the count unchanged.
- Transmitter FSM has states IDLE, START, DATA, STOP, with a bit-period counter and a 3-bit index.
  - IDLE: `TxD`=1. If the FIFO is non-empty: pop into the shift register and go to START.
  - START: `TxD`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send bits 0..7 LSB first, each for CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: `TxD`=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - IDLE always lasts at least one cycle, so there is one idle-high clock between back-to-back frames.
- `TxD` is registered, derived from the next state and shift-register bit.

## Timing
- Reset values: `Done`=0, `Pass`=0, `TxD`=1, `TxBusy`=0, `ovf`=0, FIFO empty, FSM IDLE, counters 0. `ReadData` follows the decode and reads 0 for CONSOLE.
- Reset asserted mid-frame: `TxD` returns high immediately (asynchronous), and queued bytes are discarded.
- Store latency: RAM, register, and FIFO updates are visible to loads in the cycle after the store edge.
- Console latency: for a store sampled at edge k into an empty FIFO with FSM IDLE:
  - Pop occurs at edge k+1.
  - `TxD` falls after edge k+1.
  - The frame occupies 10*CLKS_PER_BIT clocks.
  - `TxD` returns to idle after edge k+1+10*CLKS_PER_BIT.
- Back-to-back frames: the next start bit begins one clock after the previous stop bit ends. Period is 10*CLKS_PER_BIT+1.
- `TxBusy` rises the cycle after the push edge and falls the cycle after the final stop-bit clock with the FIFO empty.

## Test plan
1. RAM: store 0x1234_5678 to 0x64, then load 0x64 → `ReadData`=0x1234_5678. Load 0x66 returns the same word. Load 0x9000_0000 → 0.
2. Console single byte, CLKS_PER_BIT=4: store 0x41 to 0x8000_0000 → `TxD` sequence 0,1,0,0,0,0,0,1,0,1, each held 4 clocks, starting after edge k+1. `TxBusy` is high for 41 clocks.
3. FIFO overflow, FIFO_DEPTH=8, transmitter stalled mid-frame: push 10 bytes in consecutive cycles.
   - STATUS reads full=1, ovf=1.
   - Exactly 9 bytes are transmitted (1 in flight + 8 queued) in order, each separated by one idle clock.
4. Result: store 25 to 0x8000_0008 → `Done`=1, `Pass`=0. Then store 1 → `Pass`=1. Load returns 3.
5. Reset during the DATA state of a frame with 3 bytes queued → `TxD`=1 immediately, `TxBusy`=0, STATUS=0x1, `Done`=`Pass`=0. No further frames are sent after release.
6. Push while full coincident with pop at IDLE → byte accepted, `ovf` stays 0, count stays FIFO_DEPTH.
